// File: rtl/bz_obstacle_sched.sv
// Obstacle spawn scheduler: decodes obstacle-ROM words into a type and a tick delay,
// counts the delay down on scroll ticks, then pulses spawn and advances the ROM address counter.
module bz_obstacle_sched #(
    parameter int ROM_LAT = 1,
    parameter int MIN_GAP = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run,
    input  logic        pause,
    input  logic        tick,
    input  logic [11:0] rom_data,
    output logic        cnt_en,
    output logic        spawn,
    output logic [2:0]  spawn_type,
    output logic        wrap,
    output logic        err,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SPAWN  = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [2:0] LAT = 3'(ROM_LAT);
    localparam logic [8:0] GAP = 9'(MIN_GAP);

    logic [2:0] state;
    logic [2:0] lat_cnt;
    logic [8:0] dly;
    logic       wrapped;
    logic [2:0] type_q;

    // Delays shorter than the minimum gap are raised to it.
    function automatic logic [8:0] clamp_gap(input logic [8:0] d);
        return (d < GAP) ? GAP : d;
    endfunction

    function automatic logic [8:0] sat_dec(input logic [8:0] d);
        return (d == 9'd0) ? 9'd0 : d - 9'd1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            lat_cnt    <= 3'd0;
            dly        <= 9'd0;
            wrapped    <= 1'b0;
            type_q     <= 3'd0;
            cnt_en     <= 1'b0;
            spawn      <= 1'b0;
            spawn_type <= 3'd0;
            wrap       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt_en <= 1'b0;
            spawn  <= 1'b0;
            wrap   <= 1'b0;
            if (!run) begin
                // Stopping leaves the address counter alone so the same word is re-read on resume.
                state   <= S_IDLE;
                dly     <= 9'd0;
                wrapped <= 1'b0;
                err     <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state   <= S_FETCH;
                        lat_cnt <= LAT;
                        busy    <= 1'b1;
                    end
                    S_FETCH: begin
                        if (lat_cnt <= 3'd1) state <= S_DECODE;
                        lat_cnt <= (lat_cnt == 3'd0) ? 3'd0 : lat_cnt - 3'd1;
                    end
                    S_DECODE: begin
                        if (rom_data == 12'h000) begin
                            if (wrapped) begin
                                state <= S_ERR;
                                err   <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state   <= S_FETCH;
                                lat_cnt <= LAT;
                                cnt_en  <= 1'b1;
                                wrap    <= 1'b1;
                                wrapped <= 1'b1;
                            end
                        end else begin
                            state   <= S_WAIT;
                            wrapped <= 1'b0;
                            type_q  <= rom_data[11:9];
                            dly     <= clamp_gap(rom_data[8:0]);
                        end
                    end
                    S_WAIT: begin
                        if (tick && !pause) begin
                            dly <= sat_dec(dly);
                            // Pulses are registered here so they appear while the state is SPAWN.
                            if (dly <= 9'd1) begin
                                state      <= S_SPAWN;
                                spawn      <= 1'b1;
                                cnt_en     <= 1'b1;
                                spawn_type <= type_q;
                            end
                        end
                    end
                    S_SPAWN: begin
                        state   <= S_FETCH;
                        lat_cnt <= LAT;
                    end
                    S_ERR: begin
                        state <= S_ERR;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
